// File: rtl/maquina_pkg.sv
// Shared vending-machine definitions: money width, default coin values and state encoding.
// Optional macro ACK_TIMEOUT_EN adds the FALLA state used by the ack-timeout fault.
package maquina_pkg;

  localparam int MONEY_W      = 4;
  localparam int DEN_ALTA_DEF = 2;
  localparam int DEN_BAJA_DEF = 1;

  typedef logic [MONEY_W-1:0] dinero_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_REQ_ALTA = 3'd2;
  localparam logic [2:0] ST_REQ_BAJA = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
`ifdef ACK_TIMEOUT_EN
  localparam logic [2:0] ST_FALLA    = 3'd6;
`endif

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SELECT   = ST_SELECT,
    REQ_ALTA = ST_REQ_ALTA,
    REQ_BAJA = ST_REQ_BAJA,
    GAP      = ST_GAP,
`ifdef ACK_TIMEOUT_EN
    FALLA    = ST_FALLA,
`endif
    DONE     = ST_DONE
  } estado_t;

endpackage

// File: rtl/dispensador_cambio_if.sv
// Bundle between the vending top level / coin ejector and the change dispenser.
// The dispenser uses the slave modport; the driver of sales and acks uses master.
interface dispensador_cambio_if;
  import maquina_pkg::*;

  dinero_t cambio;
  logic    vend;
  logic    ack;
  logic    req_alta;
  logic    req_baja;
  dinero_t restante;
  logic    ocupado;
  logic    fin;
  logic    falla;

  modport master (
    output cambio, vend, ack,
    input  req_alta, req_baja, restante, ocupado, fin, falla
  );

  modport slave (
    input  cambio, vend, ack,
    output req_alta, req_baja, restante, ocupado, fin, falla
  );

endinterface

// File: rtl/dispensador_cambio_pausa.sv
// contador_pausa: loadable down-counter that stops at zero and flags it.
// Used for the inter-coin gap and, with ACK_TIMEOUT_EN, for the ack timeout.
module contador_pausa #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             carga,
  input  logic [WIDTH-1:0] valor,
  input  logic             habilita,
  output logic             cero
);

  logic [WIDTH-1:0] cuenta;

  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta <= '0;
    end else if (carga) begin
      cuenta <= valor;
    end else if (habilita && (cuenta != '0)) begin
      cuenta <= cuenta - WIDTH'(1);
    end
  end

  assign cero = (cuenta == '0);

endmodule

// File: rtl/dispensador_cambio.sv
// dispensador_cambio: pays out change one coin at a time (greedy, two denominations) via req/ack.
// Optional macro ACK_TIMEOUT_EN: missing ack for TIMEOUT_CYCLES cycles latches a sticky fault.
module dispensador_cambio
  import maquina_pkg::*;
#(
  parameter int DEN_ALTA       = DEN_ALTA_DEF,
  parameter int DEN_BAJA       = DEN_BAJA_DEF,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 reset,
  dispensador_cambio_if.slave bus
);

  if ((DEN_BAJA < 1) || (DEN_ALTA <= DEN_BAJA) || (DEN_ALTA > 15) ||
      (GAP_CYCLES < 0) || (GAP_CYCLES > 15) ||
      (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_param_invalido
    $error("dispensador_cambio: illegal parameter combination");
  end

  localparam dinero_t    ALTA      = dinero_t'(DEN_ALTA);
  localparam dinero_t    BAJA      = dinero_t'(DEN_BAJA);
  localparam logic [3:0] GAP_CARGA = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  estado_t estado, siguiente;

  dinero_t restante_q;
  logic    req_alta_q, req_baja_q, ocupado_q, fin_q;
  logic    ack_alta, ack_baja;
  logic    gap_cero;

  assign ack_alta = (estado == REQ_ALTA) && bus.ack;
  assign ack_baja = (estado == REQ_BAJA) && bus.ack;

  // The gap counter is loaded with GAP_CYCLES-1 on the acknowledging edge so GAP lasts GAP_CYCLES cycles.
  contador_pausa #(.WIDTH(4)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .carga    (ack_alta | ack_baja),
    .valor    (GAP_CARGA),
    .habilita (estado == GAP),
    .cero     (gap_cero)
  );

`ifdef ACK_TIMEOUT_EN
  localparam logic [7:0] TO_CARGA = 8'(TIMEOUT_CYCLES - 1);

  logic to_cero;
  logic falla_q;

  // SELECT always precedes a request state, so loading there restarts the timeout per coin.
  contador_pausa #(.WIDTH(8)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .carga    (estado == SELECT),
    .valor    (TO_CARGA),
    .habilita ((estado == REQ_ALTA) || (estado == REQ_BAJA)),
    .cero     (to_cero)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= IDLE;
    end else begin
      estado <= siguiente;
    end
  end

  always_comb begin
    siguiente = estado;
    case (estado)
      IDLE: begin
        if (bus.vend) begin
          siguiente = (bus.cambio != '0) ? SELECT : DONE;
        end
      end
      SELECT: begin
        if (restante_q >= ALTA) begin
          siguiente = REQ_ALTA;
        end else if (restante_q >= BAJA) begin
          siguiente = REQ_BAJA;
        end else begin
          siguiente = DONE;
        end
      end
      REQ_ALTA, REQ_BAJA: begin
        if (bus.ack) begin
          siguiente = (GAP_CYCLES == 0) ? SELECT : GAP;
        end
`ifdef ACK_TIMEOUT_EN
        else if (to_cero) begin
          siguiente = FALLA;
        end
`endif
      end
      GAP: begin
        if (gap_cero) begin
          siguiente = SELECT;
        end
      end
      DONE: begin
        siguiente = IDLE;
      end
`ifdef ACK_TIMEOUT_EN
      FALLA: begin
        siguiente = FALLA;
      end
`endif
      default: begin
        siguiente = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_alta_q <= 1'b0;
      req_baja_q <= 1'b0;
      ocupado_q  <= 1'b0;
      fin_q      <= 1'b0;
      restante_q <= '0;
    end else begin
      req_alta_q <= (siguiente == REQ_ALTA);
      req_baja_q <= (siguiente == REQ_BAJA);
      ocupado_q  <= (siguiente != IDLE);
      fin_q      <= (siguiente == DONE);
      if ((estado == IDLE) && bus.vend) begin
        restante_q <= bus.cambio;
      end else if (ack_alta) begin
        restante_q <= restante_q - ALTA;
      end else if (ack_baja) begin
        restante_q <= restante_q - BAJA;
      end
    end
  end

`ifdef ACK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      falla_q <= 1'b0;
    end else begin
      falla_q <= (siguiente == FALLA);
    end
  end

  assign bus.falla = falla_q;
`else
  assign bus.falla = 1'b0;
`endif

  assign bus.req_alta = req_alta_q;
  assign bus.req_baja = req_baja_q;
  assign bus.ocupado  = ocupado_q;
  assign bus.fin      = fin_q;
  assign bus.restante = restante_q;

endmodule

// File: tb/tb_dispensador_cambio.sv
// Self-checking bench for dispensador_cambio: directed scenarios plus randomized sales
// checked against a greedy coin-plan model computed with plain arithmetic.
module tb_dispensador_cambio;
  import maquina_pkg::*;

  localparam int DA  = 2;
  localparam int DB  = 1;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic reset;

  dispensador_cambio_if bus ();

  dispensador_cambio #(
    .DEN_ALTA       (DA),
    .DEN_BAJA       (DB),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int plan[$];
  int plan_resid;

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the greedy coin list a sale of c must produce.
  task automatic build_plan(input int c);
    int rem;
    plan.delete();
    rem = c;
    while (rem >= DA) begin
      plan.push_back(DA);
      rem -= DA;
    end
    while (rem >= DB) begin
      plan.push_back(DB);
      rem -= DB;
    end
    plan_resid = rem;
  endtask

  task automatic applyStimulus(input int c);
    @(negedge clk);
    bus.vend   = 1'b1;
    bus.cambio = dinero_t'(c);
    @(negedge clk);
    bus.vend   = 1'b0;
    bus.cambio = dinero_t'($urandom_range(15, 0));
  endtask

  task automatic wait_event(input int budget, output int idle, output bit seen);
    idle = 0;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.req_alta || bus.req_baja || bus.fin) begin
        seen = 1'b1;
        break;
      end
      idle++;
      @(negedge clk);
    end
  endtask

  // delay < 0 picks a random ack delay of 0..4 cycles per coin.
  task automatic run_sale(input int c, input int delay, input bit inject);
    int  rem, idle, d;
    bit  seen;
    build_plan(c);
    rem = c;
    applyStimulus(c);
    checkOutput("ocupado_after_vend", int'(bus.ocupado), 1);
    foreach (plan[k]) begin
      wait_event(40, idle, seen);
      checkOutput("req_seen", int'(seen), 1);
      if (!seen) return;
      checkOutput("req_latency", idle, (k == 0) ? 1 : GAP + 1);
      checkOutput("req_alta", int'(bus.req_alta), int'(plan[k] == DA));
      checkOutput("req_baja", int'(bus.req_baja), int'(plan[k] == DB));
      checkOutput("restante_pre", int'(bus.restante), rem);
      checkOutput("ocupado_req", int'(bus.ocupado), 1);
      d = (delay >= 0) ? delay : int'($urandom_range(4, 0));
      if (inject && (k == 0) && (d == 0)) d = 1;
      for (int i = 0; i < d; i++) begin
        if (inject && (k == 0) && (i == 0)) begin
          bus.vend   = 1'b1;
          bus.cambio = dinero_t'(3);
        end
        @(negedge clk);
        bus.vend = 1'b0;
        checkOutput("req_hold", int'({bus.req_alta, bus.req_baja}), (plan[k] == DA) ? 2 : 1);
        checkOutput("restante_hold", int'(bus.restante), rem);
      end
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      rem -= plan[k];
      checkOutput("req_drop", int'(bus.req_alta | bus.req_baja), 0);
      checkOutput("restante_post", int'(bus.restante), rem);
    end
    wait_event(40, idle, seen);
    checkOutput("fin_seen", int'(seen), 1);
    if (!seen) return;
    checkOutput("fin_latency", idle, (c == 0) ? 0 : ((plan.size() == 0) ? 1 : GAP + 1));
    checkOutput("fin", int'(bus.fin), 1);
    checkOutput("fin_no_req", int'(bus.req_alta | bus.req_baja), 0);
    checkOutput("restante_fin", int'(bus.restante), plan_resid);
    checkOutput("falla", int'(bus.falla), 0);
    @(negedge clk);
    checkOutput("fin_single", int'(bus.fin), 0);
    checkOutput("ocupado_idle", int'(bus.ocupado), 0);
    checkOutput("restante_kept", int'(bus.restante), plan_resid);
  endtask

  initial begin
    int  idle;
    bit  seen;
    int  c;

    reset      = 1'b1;
    bus.vend   = 1'b0;
    bus.ack    = 1'b0;
    bus.cambio = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_alta", int'(bus.req_alta), 0);
    checkOutput("rst_req_baja", int'(bus.req_baja), 0);
    checkOutput("rst_restante", int'(bus.restante), 0);
    checkOutput("rst_ocupado", int'(bus.ocupado), 0);
    checkOutput("rst_fin", int'(bus.fin), 0);
    checkOutput("rst_falla", int'(bus.falla), 0);
    reset = 1'b0;

    $display("[TB] directed sales");
    run_sale(7, 1, 1'b0);
    run_sale(0, 1, 1'b0);
    run_sale(4, 10, 1'b0);
    run_sale(15, 2, 1'b1);
    run_sale(3, 0, 1'b0);

    $display("[TB] reset during payout");
    applyStimulus(7);
    wait_event(40, idle, seen);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    wait_event(40, idle, seen);
    checkOutput("midrst_req_alta", int'(bus.req_alta), 1);
    checkOutput("midrst_restante", int'(bus.restante), 5);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_req", int'({bus.req_alta, bus.req_baja}), 0);
    checkOutput("midrst_out_restante", int'(bus.restante), 0);
    checkOutput("midrst_out_ocupado", int'(bus.ocupado), 0);
    checkOutput("midrst_out_fin", int'(bus.fin), 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_no_fin", int'(bus.fin), 0);
    checkOutput("midrst_idle", int'(bus.ocupado), 0);
    run_sale(5, 1, 1'b0);

    $display("[TB] randomized sales");
    for (int n = 0; n < 12; n++) begin
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      @(negedge clk);
      checkOutput("idle_ack_ignored", int'({bus.req_alta, bus.req_baja, bus.ocupado}), 0);
      c = int'($urandom_range(15, 0));
      run_sale(c, -1, 1'(($urandom_range(1, 0))));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
